// File: rtl/dispatch_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// dispatch_scheduler_pkg
// Shared constants and types for the dispatch scheduler:
//   - head-window width, counter/free-count widths, recovery length
//   - dispatch FSM state encoding (RUN/RECOVER/SERIALIZE)
//   - packed per-slot attribute record {branch, need_dst, ldst, serial}
// ---------------------------------------------------------------------------
package dispatch_scheduler_pkg;

    localparam int DISPATCH_WIDTH = 4;
    localparam int CNT_W          = 6;
    localparam int FREE_W         = 8;
    localparam int RECOVER_CYCLES = 2;

    // Width of the dispatch count (0..DISPATCH_WIDTH inclusive).
    localparam int DCNT_W = $clog2(DISPATCH_WIDTH) + 1;
    // Recovery counter width; fixed so RECOVER_CYCLES=0 still yields a legal vector.
    localparam int RCNT_W = 4;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_RECOVER   = 2'd1,
        ST_SERIALIZE = 2'd2
    } disp_state_e;

    typedef struct packed {
        logic branch;
        logic need_dst;
        logic ldst;
        logic serial;
    } slot_attr_t;

    // Thermometer mask with the lowest n bits set (slot 0 first).
    function automatic logic [DISPATCH_WIDTH-1:0] thermo_mask(input logic [DCNT_W-1:0] n);
        logic [DISPATCH_WIDTH-1:0] m;
        m = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            m[k] = (DCNT_W'(k) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/dispatch_scheduler_prefix_limit.sv
// ---------------------------------------------------------------------------
// dispatch_prefix_limit
// Purely combinational. For every prefix length k of the head window it
// accumulates popcounts of need_dst / ldst / branch and checks them, plus k
// itself, against the free-resource counts and the buffer occupancy. Returns
// the largest fitting k. A serializing slot 0 is dispatched alone and only
// when the active list is empty.
// Ports:
//   inst_count_i   valid buffer entries
//   slots_i        packed attributes of head slots 0..DISPATCH_WIDTH-1
//   free_*_i       free physical regs / IQ / AL / LSQ / checkpoints
//   al_empty_i     active list empty
//   limit_o        candidate dispatch count n
// ---------------------------------------------------------------------------
module dispatch_prefix_limit
    import dispatch_scheduler_pkg::*;
(
    input  logic [CNT_W-1:0]                      inst_count_i,
    input  slot_attr_t [DISPATCH_WIDTH-1:0]       slots_i,
    input  logic [FREE_W-1:0]                     free_phy_i,
    input  logic [FREE_W-1:0]                     free_iq_i,
    input  logic [FREE_W-1:0]                     free_al_i,
    input  logic [FREE_W-1:0]                     free_lsq_i,
    input  logic [FREE_W-1:0]                     free_ckpt_i,
    input  logic                                  al_empty_i,
    output logic [DCNT_W-1:0]                     limit_o
);

    logic [FREE_W-1:0] pop_dst;
    logic [FREE_W-1:0] pop_ldst;
    logic [FREE_W-1:0] pop_br;
    logic              prefix_ok;
    logic [DCNT_W-1:0] limit_raw;

    // Walk prefixes; every constraint is monotone in k, so the first failure ends the run.
    always_comb begin
        pop_dst   = '0;
        pop_ldst  = '0;
        pop_br    = '0;
        prefix_ok = 1'b1;
        limit_raw = '0;
        for (int k = 1; k <= DISPATCH_WIDTH; k++) begin
            pop_dst  = pop_dst  + FREE_W'(slots_i[k-1].need_dst);
            pop_ldst = pop_ldst + FREE_W'(slots_i[k-1].ldst);
            pop_br   = pop_br   + FREE_W'(slots_i[k-1].branch);
            if ((CNT_W'(k) > inst_count_i)  ||
                (pop_dst  > free_phy_i)     ||
                (FREE_W'(k) > free_iq_i)    ||
                (FREE_W'(k) > free_al_i)    ||
                (pop_ldst > free_lsq_i)     ||
                (pop_br   > free_ckpt_i)    ||
                ((k > 1) && slots_i[k-1].serial)) begin
                prefix_ok = 1'b0;
            end else begin
                prefix_ok = prefix_ok;
            end
            if (prefix_ok) begin
                limit_raw = DCNT_W'(k);
            end else begin
                limit_raw = limit_raw;
            end
        end
    end

    // Serializing head goes alone, and only into an empty active list.
    always_comb begin
        if (slots_i[0].serial) begin
            if ((limit_raw != '0) && al_empty_i) begin
                limit_o = DCNT_W'(1);
            end else begin
                limit_o = '0;
            end
        end else begin
            limit_o = limit_raw;
        end
    end

endmodule

// File: rtl/dispatch_scheduler.sv
// ---------------------------------------------------------------------------
// dispatch_scheduler
// Decides each cycle how many instructions leave the instruction-buffer head.
// Outputs are combinational from current inputs and registered state; the
// FSM (RUN/RECOVER/SERIALIZE), recovery counter and saturating stall counter
// update on the rising clock edge.
// Ports:
//   clk, reset (async, active-low)
//   flush_i, instCount_i, inst{Branch,NeedDst,LdSt,Serial}_i
//   free{PhyReg,Iq,Al,Lsq,Ckpt}_i, renameReady_i, alEmpty_i, serialCommit_i
//   dispatchCount_o, dispatchValid_o, dispatchStall_o, state_o, stallCycles_o
// ---------------------------------------------------------------------------
module dispatch_scheduler
    import dispatch_scheduler_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_i,
    input  logic [CNT_W-1:0]            instCount_i,
    input  logic [DISPATCH_WIDTH-1:0]   instBranch_i,
    input  logic [DISPATCH_WIDTH-1:0]   instNeedDst_i,
    input  logic [DISPATCH_WIDTH-1:0]   instLdSt_i,
    input  logic [DISPATCH_WIDTH-1:0]   instSerial_i,
    input  logic [FREE_W-1:0]           freePhyReg_i,
    input  logic [FREE_W-1:0]           freeIq_i,
    input  logic [FREE_W-1:0]           freeAl_i,
    input  logic [FREE_W-1:0]           freeLsq_i,
    input  logic [FREE_W-1:0]           freeCkpt_i,
    input  logic                        renameReady_i,
    input  logic                        alEmpty_i,
    input  logic                        serialCommit_i,
    output logic [DCNT_W-1:0]           dispatchCount_o,
    output logic [DISPATCH_WIDTH-1:0]   dispatchValid_o,
    output logic                        dispatchStall_o,
    output logic [1:0]                  state_o,
    output logic [31:0]                 stallCycles_o
);

    slot_attr_t [DISPATCH_WIDTH-1:0] slots;
    logic [DCNT_W-1:0]               limit;
    logic [DCNT_W-1:0]               disp_cnt;
    logic                            disp_stall;

    disp_state_e       state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    // Pack the per-slot attribute vectors into slot records.
    always_comb begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            slots[k].branch   = instBranch_i[k];
            slots[k].need_dst = instNeedDst_i[k];
            slots[k].ldst     = instLdSt_i[k];
            slots[k].serial   = instSerial_i[k];
        end
    end

    dispatch_prefix_limit u_prefix_limit (
        .inst_count_i (instCount_i),
        .slots_i      (slots),
        .free_phy_i   (freePhyReg_i),
        .free_iq_i    (freeIq_i),
        .free_al_i    (freeAl_i),
        .free_lsq_i   (freeLsq_i),
        .free_ckpt_i  (freeCkpt_i),
        .al_empty_i   (alEmpty_i),
        .limit_o      (limit)
    );

    // Dispatch only in RUN with rename ready, no flush and reset released.
    always_comb begin
        if (reset && (state_q == ST_RUN) && renameReady_i && !flush_i) begin
            disp_cnt = limit;
        end else begin
            disp_cnt = '0;
        end
        disp_stall = reset && (instCount_i != '0) && (disp_cnt == '0);
    end

    assign dispatchCount_o = disp_cnt;
    assign dispatchValid_o = thermo_mask(disp_cnt);
    assign dispatchStall_o = disp_stall;
    assign state_o         = state_q;
    assign stallCycles_o   = stall_cnt_q;

    // Next-state, recovery counter and stall counter; flush wins in every state.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_RECOVER;
                    rcnt_d  = RCNT_W'(RECOVER_CYCLES);
                end else if ((disp_cnt != '0) && instSerial_i[0]) begin
                    state_d = ST_SERIALIZE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RECOVER: begin
                // Decrement-then-test: RECOVER_CYCLES of 0 or 1 both give one cycle.
                if (flush_i) begin
                    rcnt_d = RCNT_W'(RECOVER_CYCLES);
                end else if (rcnt_q <= RCNT_W'(1)) begin
                    state_d = ST_RUN;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q - RCNT_W'(1);
                end
            end
            ST_SERIALIZE: begin
                if (flush_i) begin
                    state_d = ST_RECOVER;
                    rcnt_d  = RCNT_W'(RECOVER_CYCLES);
                end else if (serialCommit_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SERIALIZE;
                end
            end
            default: begin
                state_d = ST_RUN;
                rcnt_d  = '0;
            end
        endcase

        if ((state_q == ST_RUN) && disp_stall && !flush_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            rcnt_q      <= '0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_dispatch_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dispatch_scheduler
// Table of single-cycle RUN vectors with hand-computed results, followed by
// directed sequences for flush recovery, serialization, reset and saturation.
// ---------------------------------------------------------------------------
module tb_dispatch_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush_i = 1'b0;
    logic [5:0]  instCount_i = 6'd0;
    logic [3:0]  instBranch_i = 4'd0;
    logic [3:0]  instNeedDst_i = 4'd0;
    logic [3:0]  instLdSt_i = 4'd0;
    logic [3:0]  instSerial_i = 4'd0;
    logic [7:0]  freePhyReg_i = 8'd8;
    logic [7:0]  freeIq_i = 8'd8;
    logic [7:0]  freeAl_i = 8'd8;
    logic [7:0]  freeLsq_i = 8'd8;
    logic [7:0]  freeCkpt_i = 8'd8;
    logic        renameReady_i = 1'b1;
    logic        alEmpty_i = 1'b0;
    logic        serialCommit_i = 1'b0;
    logic [2:0]  dispatchCount_o;
    logic [3:0]  dispatchValid_o;
    logic        dispatchStall_o;
    logic [1:0]  state_o;
    logic [31:0] stallCycles_o;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_stall = 32'd0;

    dispatch_scheduler dut (
        .clk             (clk),
        .reset           (reset),
        .flush_i         (flush_i),
        .instCount_i     (instCount_i),
        .instBranch_i    (instBranch_i),
        .instNeedDst_i   (instNeedDst_i),
        .instLdSt_i      (instLdSt_i),
        .instSerial_i    (instSerial_i),
        .freePhyReg_i    (freePhyReg_i),
        .freeIq_i        (freeIq_i),
        .freeAl_i        (freeAl_i),
        .freeLsq_i       (freeLsq_i),
        .freeCkpt_i      (freeCkpt_i),
        .renameReady_i   (renameReady_i),
        .alEmpty_i       (alEmpty_i),
        .serialCommit_i  (serialCommit_i),
        .dispatchCount_o (dispatchCount_o),
        .dispatchValid_o (dispatchValid_o),
        .dispatchStall_o (dispatchStall_o),
        .state_o         (state_o),
        .stallCycles_o   (stallCycles_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] cnt;
        logic [3:0] br, dst, ls, ser;
        logic [7:0] phy, iq, al, lsq, ck;
        logic       rr, ale;
        logic [2:0] e_cnt;
        logic [3:0] e_val;
        logic       e_stall;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic [5:0] c, input logic [3:0] br, input logic [3:0] dst,
                                input logic [3:0] ls, input logic [3:0] ser,
                                input logic [7:0] phy, input logic [7:0] iq, input logic [7:0] al,
                                input logic [7:0] lsq, input logic [7:0] ck,
                                input logic rr, input logic ale,
                                input logic [2:0] ec, input logic [3:0] ev, input logic es);
        vec_t v;
        v.cnt = c; v.br = br; v.dst = dst; v.ls = ls; v.ser = ser;
        v.phy = phy; v.iq = iq; v.al = al; v.lsq = lsq; v.ck = ck;
        v.rr = rr; v.ale = ale;
        v.e_cnt = ec; v.e_val = ev; v.e_stall = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ample();
        instCount_i = 6'd6;
        instBranch_i = 4'd0; instNeedDst_i = 4'd0; instLdSt_i = 4'd0; instSerial_i = 4'd0;
        freePhyReg_i = 8'd8; freeIq_i = 8'd8; freeAl_i = 8'd8; freeLsq_i = 8'd8; freeCkpt_i = 8'd8;
        renameReady_i = 1'b1; alEmpty_i = 1'b0; flush_i = 1'b0; serialCommit_i = 1'b0;
    endtask

    initial begin
        //             cnt    br     dst    ls     ser    phy     iq     al     lsq    ck     rr    ale   cnt   val    stall
        vecs[0]  = mk(6'd6, 4'h0, 4'hF, 4'h0, 4'h0, 8'd2,   8'd8,  8'd8,  8'd8,  8'd8, 1'b1, 1'b0, 3'd2, 4'h3, 1'b0);
        vecs[1]  = mk(6'd6, 4'h1, 4'h0, 4'h0, 4'h0, 8'd8,   8'd8,  8'd8,  8'd8,  8'd0, 1'b1, 1'b0, 3'd0, 4'h0, 1'b1);
        vecs[2]  = mk(6'd0, 4'h0, 4'h0, 4'h0, 4'h0, 8'd8,   8'd8,  8'd8,  8'd8,  8'd8, 1'b1, 1'b0, 3'd0, 4'h0, 1'b0);
        vecs[3]  = mk(6'd3, 4'h0, 4'h0, 4'h0, 4'h0, 8'd8,   8'd8,  8'd8,  8'd8,  8'd8, 1'b1, 1'b0, 3'd3, 4'h7, 1'b0);
        vecs[4]  = mk(6'd6, 4'h0, 4'h0, 4'h0, 4'h0, 8'd8,   8'd8,  8'd8,  8'd8,  8'd8, 1'b1, 1'b0, 3'd4, 4'hF, 1'b0);
        vecs[5]  = mk(6'd6, 4'h0, 4'h0, 4'h0, 4'h4, 8'd8,   8'd8,  8'd8,  8'd8,  8'd8, 1'b1, 1'b0, 3'd2, 4'h3, 1'b0);
        vecs[6]  = mk(6'd6, 4'h0, 4'h0, 4'h0, 4'h1, 8'd8,   8'd8,  8'd8,  8'd8,  8'd8, 1'b1, 1'b0, 3'd0, 4'h0, 1'b1);
        vecs[7]  = mk(6'd6, 4'h0, 4'h0, 4'h0, 4'h0, 8'd8,   8'd8,  8'd8,  8'd8,  8'd8, 1'b0, 1'b0, 3'd0, 4'h0, 1'b1);
        vecs[8]  = mk(6'd6, 4'h0, 4'h0, 4'h0, 4'h0, 8'd8,   8'd1,  8'd8,  8'd8,  8'd8, 1'b1, 1'b0, 3'd1, 4'h1, 1'b0);
        vecs[9]  = mk(6'd6, 4'h0, 4'h0, 4'hF, 4'h0, 8'd8,   8'd8,  8'd8,  8'd3,  8'd8, 1'b1, 1'b0, 3'd3, 4'h7, 1'b0);
        vecs[10] = mk(6'd6, 4'h6, 4'h0, 4'h0, 4'h0, 8'd8,   8'd8,  8'd8,  8'd8,  8'd1, 1'b1, 1'b0, 3'd2, 4'h3, 1'b0);
        vecs[11] = mk(6'd6, 4'h0, 4'h0, 4'h0, 4'h0, 8'd8,   8'd8,  8'd0,  8'd8,  8'd8, 1'b1, 1'b0, 3'd0, 4'h0, 1'b1);
        vecs[12] = mk(6'd6, 4'h0, 4'h0, 4'h0, 4'h2, 8'd8,   8'd8,  8'd8,  8'd8,  8'd8, 1'b1, 1'b0, 3'd1, 4'h1, 1'b0);
        vecs[13] = mk(6'd6, 4'h0, 4'h1, 4'h0, 4'h1, 8'd0,   8'd8,  8'd8,  8'd8,  8'd8, 1'b1, 1'b1, 3'd0, 4'h0, 1'b1);
        vecs[14] = mk(6'd6, 4'h0, 4'h0, 4'h0, 4'h0, 8'd255, 8'd200, 8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 3'd4, 4'hF, 1'b0);
        vecs[15] = mk(6'd6, 4'h0, 4'hA, 4'h0, 4'h0, 8'd1,   8'd8,  8'd8,  8'd8,  8'd8, 1'b1, 1'b0, 3'd3, 4'h7, 1'b0);

        // Reset held low with a full buffer: everything quiet.
        set_ample();
        @(negedge clk); #1;
        chk("rst_cnt",   32'(dispatchCount_o), 32'd0);
        chk("rst_valid", 32'(dispatchValid_o), 32'd0);
        chk("rst_stall", 32'(dispatchStall_o), 32'd0);
        chk("rst_state", 32'(state_o),         32'd0);
        chk("rst_scyc",  stallCycles_o,        32'd0);
        reset = 1'b1;

        // Table of single-cycle RUN vectors.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            instCount_i = vecs[i].cnt;   instBranch_i = vecs[i].br;
            instNeedDst_i = vecs[i].dst; instLdSt_i = vecs[i].ls;  instSerial_i = vecs[i].ser;
            freePhyReg_i = vecs[i].phy;  freeIq_i = vecs[i].iq;    freeAl_i = vecs[i].al;
            freeLsq_i = vecs[i].lsq;     freeCkpt_i = vecs[i].ck;
            renameReady_i = vecs[i].rr;  alEmpty_i = vecs[i].ale;
            #1;
            chk($sformatf("v%0d_cnt", i),   32'(dispatchCount_o), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_valid", i), 32'(dispatchValid_o), 32'(vecs[i].e_val));
            chk($sformatf("v%0d_stall", i), 32'(dispatchStall_o), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_state", i), 32'(state_o),         32'd0);
            exp_stall = exp_stall + 32'(vecs[i].e_stall);
        end
        @(negedge clk); set_ample(); instCount_i = 6'd0; #1;
        chk("table_scyc", stallCycles_o, exp_stall);

        // Flush recovery: flush cycle plus two RECOVER cycles dispatch nothing.
        @(negedge clk); set_ample(); flush_i = 1'b1; #1;
        chk("fl_cnt0", 32'(dispatchCount_o), 32'd0);
        @(negedge clk); flush_i = 1'b0; #1;
        chk("fl_st1",  32'(state_o), 32'd1);
        chk("fl_cnt1", 32'(dispatchCount_o), 32'd0);
        @(negedge clk); #1;
        chk("fl_st2",  32'(state_o), 32'd1);
        chk("fl_cnt2", 32'(dispatchCount_o), 32'd0);
        @(negedge clk); #1;
        chk("fl_st3",  32'(state_o), 32'd0);
        chk("fl_cnt3", 32'(dispatchCount_o), 32'd4);
        chk("fl_val3", 32'(dispatchValid_o), 32'hF);
        chk("fl_scyc", stallCycles_o, exp_stall);

        // Serialize: slot 0 goes alone into an empty AL, then wait for commit.
        @(negedge clk); instSerial_i = 4'h1; alEmpty_i = 1'b1; #1;
        chk("ser_cnt",  32'(dispatchCount_o), 32'd1);
        chk("ser_val",  32'(dispatchValid_o), 32'h1);
        @(negedge clk); instSerial_i = 4'h0; #1;
        chk("ser_st",   32'(state_o), 32'd2);
        chk("ser_hold", 32'(dispatchCount_o), 32'd0);
        @(negedge clk); serialCommit_i = 1'b1; #1;
        chk("ser_cmt_cnt", 32'(dispatchCount_o), 32'd0);
        @(negedge clk); serialCommit_i = 1'b0; #1;
        chk("ser_run", 32'(state_o), 32'd0);
        chk("ser_cnt4", 32'(dispatchCount_o), 32'd4);
        chk("ser_scyc", stallCycles_o, exp_stall);

        // Flush and commit together in SERIALIZE: flush wins.
        @(negedge clk); instSerial_i = 4'h1; #1;
        chk("sf_cnt", 32'(dispatchCount_o), 32'd1);
        @(negedge clk); instSerial_i = 4'h0; flush_i = 1'b1; serialCommit_i = 1'b1; #1;
        chk("sf_st2", 32'(state_o), 32'd2);
        @(negedge clk); flush_i = 1'b0; serialCommit_i = 1'b0; #1;
        chk("sf_rec", 32'(state_o), 32'd1);
        @(negedge clk); #1;
        chk("sf_rec2", 32'(state_o), 32'd1);
        @(negedge clk); #1;
        chk("sf_run", 32'(state_o), 32'd0);
        chk("sf_cnt4", 32'(dispatchCount_o), 32'd4);

        // Reset mid-SERIALIZE clears state and the stall counter.
        @(negedge clk); instSerial_i = 4'h1; #1;
        @(negedge clk); instSerial_i = 4'h0; #1;
        chk("rs_pre_st", 32'(state_o), 32'd2);
        reset = 1'b0; #1;
        chk("rs_st",    32'(state_o), 32'd0);
        chk("rs_scyc",  stallCycles_o, 32'd0);
        chk("rs_cnt",   32'(dispatchCount_o), 32'd0);
        chk("rs_val",   32'(dispatchValid_o), 32'd0);
        chk("rs_stall", 32'(dispatchStall_o), 32'd0);
        @(negedge clk); #1;
        chk("rs_st_b",  32'(state_o), 32'd0);
        chk("rs_cnt_b", 32'(dispatchCount_o), 32'd0);
        reset = 1'b1;
        exp_stall = 32'd0;
        @(negedge clk); #1;
        chk("rs_resume", 32'(dispatchCount_o), 32'd4);

        // Backpressure: rename not ready counts one stall cycle.
        @(negedge clk); renameReady_i = 1'b0; #1;
        chk("bp_cnt",   32'(dispatchCount_o), 32'd0);
        chk("bp_stall", 32'(dispatchStall_o), 32'd1);
        @(negedge clk); renameReady_i = 1'b1; #1;
        chk("bp_scyc", stallCycles_o, exp_stall + 32'd1);

        // Saturation: with the counter at all-ones a stall must not wrap.
        @(negedge clk); renameReady_i = 1'b0;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        chk("sat_next", dut.stall_cnt_d, 32'hFFFF_FFFF);
        release dut.stall_cnt_q;
        @(negedge clk); renameReady_i = 1'b1; reset = 1'b0; #1;
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dispatch_scheduler.md
# dispatch_scheduler

Per-cycle dispatch controller placed between the instruction buffer and rename/dispatch. Each cycle it decides how many instructions (0..DISPATCH_WIDTH) leave the buffer head. The decision depends on the buffer occupancy, the per-slot attributes of the head window, and the free-resource counts reported by the back end. A small FSM sequences flush recovery and serializing instructions, and a saturating counter records lost dispatch cycles.

## Interface
- DISPATCH_WIDTH, 4, head-window slots examined per cycle
- CNT_W, 6, width of instCount_i (INST_QUEUE_LOG+1)
- FREE_W, 8, width of every free-resource count
- RECOVER_CYCLES, 2, dead cycles after a flush before dispatch resumes (0 allowed)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- flush_i  in  1  control mispredict/exception flush
- instCount_i  in  CNT_W  valid entries in instruction buffer
- instBranch_i  in  DISPATCH_WIDTH  slot k is a branch
- instNeedDst_i  in  DISPATCH_WIDTH  slot k needs a physical destination
- instLdSt_i  in  DISPATCH_WIDTH  slot k is load/store
- instSerial_i  in  DISPATCH_WIDTH  slot k is serializing
- freePhyReg_i, freeIq_i, freeAl_i, freeLsq_i, freeCkpt_i  in  FREE_W each  free physical regs, issue-queue slots, active-list slots, LSQ slots, branch checkpoints
- renameReady_i  in  1  rename accepts this cycle
- alEmpty_i  in  1  active list empty
- serialCommit_i  in  1  pulse: the serializing instruction committed
- dispatchCount_o  out  clog2(DISPATCH_WIDTH)+1  instructions dequeued this cycle
- dispatchValid_o  out  DISPATCH_WIDTH  thermometer mask of dispatchCount_o (slot 0 first)
- dispatchStall_o  out  1  instCount_i>0 and dispatchCount_o==0
- state_o  out  2  RUN=0, RECOVER=1, SERIALIZE=2
- stallCycles_o  out  32  saturating count of stalled RUN cycles

## Operation
- Candidate n = largest k ≤ min(DISPATCH_WIDTH, instCount_i) whose prefix of slots 0..k-1 satisfies all of the following:
  - popcount(needDst) ≤ freePhyReg_i
  - k ≤ freeIq_i
  - k ≤ freeAl_i
  - popcount(ldst) ≤ freeLsq_i
  - popcount(branch) ≤ freeCkpt_i
  - no instSerial_i at any slot 1..k-1
- Serializing at slot 0: dispatched alone (n=1) only if alEmpty_i=1 and it fits the resources; otherwise n=0.
- dispatchCount_o = n in RUN with renameReady_i=1, flush_i=0, reset deasserted; 0 in every other case.
- FSM, flush_i has priority in every state:
  - RUN: flush_i -> RECOVER and load counter with RECOVER_CYCLES. Dispatch of a serializing slot 0 -> SERIALIZE.
  - RECOVER: dispatch 0. Counter decrements each cycle. At 0 -> RUN. With RECOVER_CYCLES=0, RECOVER lasts exactly one cycle.
  - SERIALIZE: dispatch 0 until serialCommit_i=1 -> RUN (dispatch allowed the following cycle). flush_i -> RECOVER (the serializing instruction is squashed).
- serialCommit_i is ignored outside SERIALIZE.
- stallCycles_o increments when state=RUN, dispatchStall_o=1 and flush_i=0. It saturates at 2^32-1 and is cleared only by reset.
- Arithmetic: prefix sums are zero-extended to FREE_W. Free counts above DISPATCH_WIDTH behave identically to DISPATCH_WIDTH.

## Timing
- Outputs are combinational from current inputs and registered state, with zero latency. The buffer consumes dispatchCount_o in the same cycle.
- State, counter and stallCycles_o update on the rising edge.
- Reset asserted, at any time including mid-SERIALIZE:
  - state RUN, counter 0, stallCycles_o 0
  - dispatchCount_o 0, dispatchValid_o 0, dispatchStall_o 0
  - operation resumes on the first edge after deassertion.
- flush_i in the same cycle as a would-be dispatch: dispatchCount_o=0.
- instCount_i=0: n=0 and dispatchStall_o=0.
- Empty buffer is not a stall.

## Structure
- Shared package holds:
  - DISPATCH_WIDTH and the width constants
  - state enum (RUN/RECOVER/SERIALIZE)
  - the packed slot-attribute struct {branch, needDst, ldst, serial}
- Sub-module dispatch_prefix_limit: purely combinational. It computes per-k prefix popcounts and fit flags and returns n. The top level holds the FSM, recovery counter and stall counter.

## Test plan
- Reset mid-run: pulse reset low during SERIALIZE -> state_o=0, stallCycles_o=0, dispatchCount_o=0 while reset is low.
- Resource clamp: instCount 6, all needDst, freePhyReg 2, others 8 -> dispatchCount_o=2, dispatchValid_o=0011. With freeCkpt 0 and a branch in slot 0 -> 0, and stallCycles_o increments.
- Flush recovery: RECOVER_CYCLES=2, flush pulse -> dispatchCount_o=0 in the flush cycle plus two more cycles, then 4 with ample resources.
- Serialize: serial in slot 2 -> dispatch 2. Then at slot 0 with alEmpty_i=0 -> 0. With alEmpty_i=1 -> 1, state SERIALIZE; dispatch 0 until serialCommit_i, then 4.
- Flush in SERIALIZE together with serialCommit_i -> state RECOVER, serialCommit_i ignored.
- Backpressure: renameReady_i=0 with full resources -> dispatchCount_o=0, dispatchStall_o=1, stallCycles_o+1. Counter preset to 2^32-1 stays saturated.
